game_board_glyph_draw: RTL and testbench

//  Parametrised, pipelined overlay that draws the game-board cell values as font glyphs onto the VGA bus.

---
 rtl/game_board_glyph_draw.sv | 227 ++++++++++++++++++++++
 tb/tb_game_board_glyph_draw.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_board_glyph_draw.sv
// game_board_glyph_draw: overlays the board cell values as font glyphs on the VGA stream.
// Three register stages (S1, S2, output); the external font ROM reads o_address between S1 and S2,
// so every bus field leaves exactly three clocks after it arrived.
module game_board_glyph_draw #(
  parameter int          SCREEN_W    = 1024,
  parameter int          SCREEN_H    = 768,
  parameter int          MAX_N       = 16,
  parameter int          GLYPH_LOG2  = 4,
  parameter int          SCALE_LOG2  = 0,
  parameter int          VAL_W       = 5,
  parameter int          ADDR_W      = 11,
  parameter int          GLYPH_BASE  = 1,
  parameter int          BLINK_LOG2  = 5,
  parameter logic [11:0] FONT_COLOR  = 12'hfff,
  parameter logic [11:0] FIXED_COLOR = 12'haaa,
  parameter logic [11:0] SEL_COLOR   = 12'h33f
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_is_game_on,
  input  logic [2:0]                 i_board_size,
  input  logic [VAL_W-1:0]           i_board [MAX_N][MAX_N],
  input  logic                       i_fixed_mask [MAX_N][MAX_N],
  input  logic [3:0]                 i_selection_x,
  input  logic [3:0]                 i_selection_y,
  output logic [ADDR_W-1:0]          o_address,
  input  logic [2**GLYPH_LOG2-1:0]   i_char_pixels,
  input  logic [10:0]                i_bus_hcount,
  input  logic [10:0]                i_bus_vcount,
  input  logic                       i_bus_hsync,
  input  logic                       i_bus_vsync,
  input  logic                       i_bus_hblnk,
  input  logic                       i_bus_vblnk,
  input  logic [11:0]                i_bus_rgb,
  output logic [10:0]                o_bus_hcount,
  output logic [10:0]                o_bus_vcount,
  output logic                       o_bus_hsync,
  output logic                       o_bus_vsync,
  output logic                       o_bus_hblnk,
  output logic                       o_bus_vblnk,
  output logic [11:0]                o_bus_rgb
);

  localparam int LOG2C = GLYPH_LOG2 + SCALE_LOG2;   // log2 of the cell side in pixels
  localparam int CW    = 13;                         // geometry width, covers 7*7 cells of 64 px
  localparam int IW    = $clog2(MAX_N);              // cell index width
  localparam int CNT_W = BLINK_LOG2 + 1;
  localparam logic [ADDR_W-1:0] CODE_OFS = ADDR_W'(GLYPH_BASE - 32'sd1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  // S0 combinational geometry
  logic [5:0]            w_n;
  logic                  w_size_ok, w_in_board, w_draw, w_empty, w_sel_ok, w_selected;
  logic                  w_blink_on, w_glyph, w_cursor, w_sel_on, w_fixed;
  logic [CW-1:0]         w_span, w_wdiff, w_hdiff, w_x0, w_y0, w_hc, w_vc, w_dx, w_dy;
  logic [IW-1:0]         w_col, w_row;
  logic [GLYPH_LOG2-1:0] w_gx, w_gy;
  logic [VAL_W-1:0]      w_value;
  logic [ADDR_W-1:0]     w_code, w_addr_next;

  // S1 / S2 / output registers
  logic [ADDR_W-1:0]     r_address;
  logic [10:0]           r_s1_hc, r_s1_vc, r_s2_hc, r_s2_vc, r_out_hc, r_out_vc;
  logic [3:0]            r_s1_ctl, r_s2_ctl, r_out_ctl;   // {hsync, vsync, hblnk, vblnk}
  logic [11:0]           r_s1_rgb, r_s2_rgb, r_out_rgb;
  logic                  r_s1_glyph, r_s1_sel_on, r_s1_fixed, r_s1_cursor;
  logic                  r_s2_glyph, r_s2_sel_on, r_s2_fixed, r_s2_cursor;
  logic [GLYPH_LOG2-1:0] r_s1_gx, r_s2_gx;
  logic [CNT_W-1:0]      r_frame_cnt;
  logic                  r_vsync_d;

  // S2 combinational composition
  logic                  w_bit;
  logic [11:0]           w_rgb;

  // S0: board placement, cell/glyph coordinates, font address and drawing attributes
  always_comb begin
    w_n        = {3'b000, i_board_size} * {3'b000, i_board_size};
    w_size_ok  = (w_n >= 6'd2) && (w_n <= 6'(MAX_N));
    w_span     = CW'(w_n) << LOG2C;
    w_wdiff    = CW'(SCREEN_W) - w_span;
    w_hdiff    = CW'(SCREEN_H) - w_span;
    w_x0       = {1'b0, w_wdiff[CW-1:1]};
    w_y0       = {1'b0, w_hdiff[CW-1:1]};
    w_hc       = CW'(i_bus_hcount);
    w_vc       = CW'(i_bus_vcount);
    w_in_board = (w_hc >= w_x0) && (w_hc < (w_x0 + w_span)) &&
                 (w_vc >= w_y0) && (w_vc < (w_y0 + w_span));
    w_dx       = w_hc - w_x0;
    w_dy       = w_vc - w_y0;
    w_col      = IW'(w_dx >> LOG2C);
    w_row      = IW'(w_dy >> LOG2C);
    // Low glyph bits of the offset divided by the replication factor
    w_gx       = GLYPH_LOG2'(w_dx >> SCALE_LOG2);
    w_gy       = GLYPH_LOG2'(w_dy >> SCALE_LOG2);
    w_value    = i_board[w_row][w_col];
    w_fixed    = i_fixed_mask[w_row][w_col];
    w_empty    = (w_value == {VAL_W{1'b0}});
    w_code     = CODE_OFS + ADDR_W'(w_value);
    w_sel_ok   = (6'(i_selection_x) < w_n) && (6'(i_selection_y) < w_n);
    w_selected = w_sel_ok && (6'(w_col) == 6'(i_selection_x)) && (6'(w_row) == 6'(i_selection_y));
    w_blink_on = ~r_frame_cnt[CNT_W-1];
    w_draw     = i_is_game_on && w_size_ok && w_in_board;
    w_glyph    = w_draw && !w_empty;
    w_sel_on   = w_draw && w_selected && w_blink_on;
    // Cursor bar: the last glyph row covers the bottom 2**SCALE_LOG2 pixel rows of the cell
    w_cursor   = w_sel_on && w_empty && (w_gy == {GLYPH_LOG2{1'b1}});
    if (w_glyph) begin
      w_addr_next = (w_code << GLYPH_LOG2) + ADDR_W'(w_gy);
    end else begin
      w_addr_next = {ADDR_W{1'b0}};
    end
  end

  // Frame counter: counts vsync rising edges, held at zero while no game is running
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vsync_d   <= 1'b0;
      r_frame_cnt <= {CNT_W{1'b0}};
    end else begin
      r_vsync_d <= i_bus_vsync;
      if (!i_is_game_on) begin
        r_frame_cnt <= {CNT_W{1'b0}};
      end else if (i_bus_vsync && !r_vsync_d) begin
        r_frame_cnt <= r_frame_cnt + CNT_ONE;
      end else begin
        r_frame_cnt <= r_frame_cnt;
      end
    end
  end

  // S1: register the font address together with the delayed bus and attributes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_address   <= {ADDR_W{1'b0}};
      r_s1_hc     <= 11'd0;
      r_s1_vc     <= 11'd0;
      r_s1_ctl    <= 4'd0;
      r_s1_rgb    <= 12'd0;
      r_s1_glyph  <= 1'b0;
      r_s1_sel_on <= 1'b0;
      r_s1_fixed  <= 1'b0;
      r_s1_cursor <= 1'b0;
      r_s1_gx     <= {GLYPH_LOG2{1'b0}};
    end else begin
      r_address   <= w_addr_next;
      r_s1_hc     <= i_bus_hcount;
      r_s1_vc     <= i_bus_vcount;
      r_s1_ctl    <= {i_bus_hsync, i_bus_vsync, i_bus_hblnk, i_bus_vblnk};
      r_s1_rgb    <= i_bus_rgb;
      r_s1_glyph  <= w_glyph;
      r_s1_sel_on <= w_sel_on;
      r_s1_fixed  <= w_fixed;
      r_s1_cursor <= w_cursor;
      r_s1_gx     <= w_gx;
    end
  end

  // S2: hold the bus and attributes while the ROM returns the glyph row
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_hc     <= 11'd0;
      r_s2_vc     <= 11'd0;
      r_s2_ctl    <= 4'd0;
      r_s2_rgb    <= 12'd0;
      r_s2_glyph  <= 1'b0;
      r_s2_sel_on <= 1'b0;
      r_s2_fixed  <= 1'b0;
      r_s2_cursor <= 1'b0;
      r_s2_gx     <= {GLYPH_LOG2{1'b0}};
    end else begin
      r_s2_hc     <= r_s1_hc;
      r_s2_vc     <= r_s1_vc;
      r_s2_ctl    <= r_s1_ctl;
      r_s2_rgb    <= r_s1_rgb;
      r_s2_glyph  <= r_s1_glyph;
      r_s2_sel_on <= r_s1_sel_on;
      r_s2_fixed  <= r_s1_fixed;
      r_s2_cursor <= r_s1_cursor;
      r_s2_gx     <= r_s1_gx;
    end
  end

  // S2 compose: pick the glyph bit (MSB = leftmost column, i.e. index ~gx) and apply colour priority
  always_comb begin
    w_bit = i_char_pixels[~r_s2_gx];
    w_rgb = r_s2_rgb;
    if (r_s2_cursor) begin
      w_rgb = SEL_COLOR;
    end else if (r_s2_glyph && w_bit) begin
      if (r_s2_sel_on) begin
        w_rgb = SEL_COLOR;
      end else if (r_s2_fixed) begin
        w_rgb = FIXED_COLOR;
      end else begin
        w_rgb = FONT_COLOR;
      end
    end else begin
      w_rgb = r_s2_rgb;
    end
  end

  // Output stage: register the composed bus
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_hc  <= 11'd0;
      r_out_vc  <= 11'd0;
      r_out_ctl <= 4'd0;
      r_out_rgb <= 12'd0;
    end else begin
      r_out_hc  <= r_s2_hc;
      r_out_vc  <= r_s2_vc;
      r_out_ctl <= r_s2_ctl;
      r_out_rgb <= w_rgb;
    end
  end

  assign o_address    = r_address;
  assign o_bus_hcount = r_out_hc;
  assign o_bus_vcount = r_out_vc;
  assign o_bus_hsync  = r_out_ctl[3];
  assign o_bus_vsync  = r_out_ctl[2];
  assign o_bus_hblnk  = r_out_ctl[1];
  assign o_bus_vblnk  = r_out_ctl[0];
  assign o_bus_rgb    = r_out_rgb;

endmodule

// File: tb/tb_game_board_glyph_draw.sv
// Bench for game_board_glyph_draw: two instances (glyph scale 1 and 2) share the stimulus.
// Stimulus pushes hand-computed expectations tagged with the cycle they are due; a monitor
// pops and compares them on the falling edge.
module tb_game_board_glyph_draw;
  localparam int MAX_N  = 16;
  localparam int VAL_W  = 5;
  localparam int ADDR_W = 11;

  typedef struct {
    int          due;
    int          vid;
    logic [10:0] hc;
    logic [10:0] vc;
    logic [3:0]  ctl;
    logic [11:0] rgb;
  } bus_exp_t;

  typedef struct {
    int                due;
    int                vid;
    logic [ADDR_W-1:0] a;
  } adr_exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic              game_on, hs, vs, hb, vb;
  logic [2:0]        bsize;
  logic [VAL_W-1:0]  board [MAX_N][MAX_N];
  logic              fmask [MAX_N][MAX_N];
  logic [3:0]        selx, sely;
  logic [10:0]       hc, vc;
  logic [11:0]       rgb;

  logic [ADDR_W-1:0] a1, a2;
  logic [15:0]       rom1, rom2;
  logic [10:0]       hc1, vc1, hc2, vc2;
  logic              hs1, vs1, hb1, vb1, hs2, vs2, hb2, vb2;
  logic [11:0]       rgb1, rgb2;

  game_board_glyph_draw #(.SCALE_LOG2(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .i_is_game_on(game_on), .i_board_size(bsize),
    .i_board(board), .i_fixed_mask(fmask), .i_selection_x(selx), .i_selection_y(sely),
    .o_address(a1), .i_char_pixels(rom1),
    .i_bus_hcount(hc), .i_bus_vcount(vc), .i_bus_hsync(hs), .i_bus_vsync(vs),
    .i_bus_hblnk(hb), .i_bus_vblnk(vb), .i_bus_rgb(rgb),
    .o_bus_hcount(hc1), .o_bus_vcount(vc1), .o_bus_hsync(hs1), .o_bus_vsync(vs1),
    .o_bus_hblnk(hb1), .o_bus_vblnk(vb1), .o_bus_rgb(rgb1));

  game_board_glyph_draw #(.SCALE_LOG2(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .i_is_game_on(game_on), .i_board_size(bsize),
    .i_board(board), .i_fixed_mask(fmask), .i_selection_x(selx), .i_selection_y(sely),
    .o_address(a2), .i_char_pixels(rom2),
    .i_bus_hcount(hc), .i_bus_vcount(vc), .i_bus_hsync(hs), .i_bus_vsync(vs),
    .i_bus_hblnk(hb), .i_bus_vblnk(vb), .i_bus_rgb(rgb),
    .o_bus_hcount(hc2), .o_bus_vcount(vc2), .o_bus_hsync(hs2), .o_bus_vsync(vs2),
    .o_bus_hblnk(hb2), .o_bus_vblnk(vb2), .o_bus_rgb(rgb2));

  // Font ROM model: row data = {addr[7:0], ~addr[7:0]}, one clock after the address
  function automatic logic [15:0] rom_row(input logic [ADDR_W-1:0] a);
    return {a[7:0], ~a[7:0]};
  endfunction

  always @(posedge clk) begin
    rom1 <= rom_row(a1);
    rom2 <= rom_row(a2);
  end

  bus_exp_t bq1[$], bq2[$];
  adr_exp_t aq1[$], aq2[$];
  int n_cmp = 0;
  int n_fail = 0;
  int vid = 0;

  // Monitor: compare every expectation on the cycle it is due
  always @(negedge clk) begin : mon
    bus_exp_t be;
    adr_exp_t ae;
    while (bq1.size() > 0 && bq1[0].due <= cyc) begin
      be = bq1.pop_front();
      n_cmp++;
      if (be.due != cyc || hc1 !== be.hc || vc1 !== be.vc || {hs1, vs1, hb1, vb1} !== be.ctl || rgb1 !== be.rgb) begin
        n_fail++;
        $display("FAIL bus1 vec%0d: got hc=%0d vc=%0d ctl=%b rgb=%h, want hc=%0d vc=%0d ctl=%b rgb=%h",
                 be.vid, hc1, vc1, {hs1, vs1, hb1, vb1}, rgb1, be.hc, be.vc, be.ctl, be.rgb);
      end
    end
    while (bq2.size() > 0 && bq2[0].due <= cyc) begin
      be = bq2.pop_front();
      n_cmp++;
      if (be.due != cyc || hc2 !== be.hc || vc2 !== be.vc || {hs2, vs2, hb2, vb2} !== be.ctl || rgb2 !== be.rgb) begin
        n_fail++;
        $display("FAIL bus2 vec%0d: got hc=%0d vc=%0d ctl=%b rgb=%h, want hc=%0d vc=%0d ctl=%b rgb=%h",
                 be.vid, hc2, vc2, {hs2, vs2, hb2, vb2}, rgb2, be.hc, be.vc, be.ctl, be.rgb);
      end
    end
    while (aq1.size() > 0 && aq1[0].due <= cyc) begin
      ae = aq1.pop_front();
      n_cmp++;
      if (ae.due != cyc || a1 !== ae.a) begin
        n_fail++;
        $display("FAIL addr1 vec%0d: got %0d, want %0d", ae.vid, a1, ae.a);
      end
    end
    while (aq2.size() > 0 && aq2[0].due <= cyc) begin
      ae = aq2.pop_front();
      n_cmp++;
      if (ae.due != cyc || a2 !== ae.a) begin
        n_fail++;
        $display("FAIL addr2 vec%0d: got %0d, want %0d", ae.vid, a2, ae.a);
      end
    end
  end

  task automatic sync();
    @(negedge clk);
  endtask

  task automatic put(input int hh, input int vv, input logic [11:0] rin, input logic vsy);
    @(negedge clk);
    hc  = 11'(hh);
    vc  = 11'(vv);
    rgb = rin;
    vs  = vsy;
    hs  = hc[0] ^ vc[0];
    hb  = hc[1];
    vb  = vc[1];
    vid++;
  endtask

  task automatic expect_bus(input int which, input logic [11:0] er, input int ea);
    bus_exp_t e;
    adr_exp_t f;
    e.due = cyc + 3; e.vid = vid; e.hc = hc; e.vc = vc; e.ctl = {hs, vs, hb, vb}; e.rgb = er;
    f.due = cyc + 1; f.vid = vid; f.a = ADDR_W'(ea);
    if (which == 1) begin
      bq1.push_back(e);
      aq1.push_back(f);
    end else begin
      bq2.push_back(e);
      aq2.push_back(f);
    end
  endtask

  task automatic px1(input int hh, input int vv, input logic [11:0] rin, input logic [11:0] er, input int ea);
    put(hh, vv, rin, 1'b0);
    expect_bus(1, er, ea);
  endtask

  task automatic px2(input int hh, input int vv, input logic [11:0] rin, input logic [11:0] er, input int ea);
    put(hh, vv, rin, 1'b0);
    expect_bus(2, er, ea);
  endtask

  // Pass-through pixel on both instances: rgb unchanged, address 0
  task automatic pxb(input int hh, input int vv, input logic [11:0] rin, input logic vsy);
    put(hh, vv, rin, vsy);
    expect_bus(1, rin, 0);
    expect_bus(2, rin, 0);
  endtask

  task automatic drain();
    int k = 0;
    while ((bq1.size() + bq2.size() + aq1.size() + aq2.size()) != 0 && k < 10) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if ((bq1.size() + bq2.size() + aq1.size() + aq2.size()) != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations pending, want 0", bq1.size() + bq2.size() + aq1.size() + aq2.size());
    end
  endtask

  task automatic check_zero(input int tag);
    n_cmp++;
    if ({a1, hc1, vc1, hs1, vs1, hb1, vb1, rgb1, a2, hc2, vc2, hs2, vs2, hb2, vb2, rgb2} !== '0) begin
      n_fail++;
      $display("FAIL reset%0d: got rgb1=%h hc1=%0d a1=%0d rgb2=%h hc2=%0d a2=%0d, want all 0",
               tag, rgb1, hc1, a1, rgb2, hc2, a2);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    game_on = 1'b1; bsize = 3'd3; selx = 4'd15; sely = 4'd15;
    for (int i = 0; i < MAX_N; i++) begin
      for (int j = 0; j < MAX_N; j++) begin
        board[i][j] = '0;
        fmask[i][j] = 1'b0;
      end
    end
    board[2][5] = 5'd7; board[2][0] = 5'd8; board[2][8] = 5'd8;
    board[0][0] = 5'd3; fmask[0][0] = 1'b1;
    hc = 11'd100; vc = 11'd100; rgb = 12'h123; hs = 1'b1; vs = 1'b0; hb = 1'b1; vb = 1'b1;

    // Reset state, then exact 3-clock latency after release
    repeat (3) @(negedge clk);
    check_zero(0);
    rst_n = 1'b1;
    pxb(100, 100, 12'h123, 1'b0);
    pxb(101, 100, 12'h456, 1'b0);
    pxb(102, 100, 12'h789, 1'b0);

    // N=9, scale 1: origin (440,312)
    px1(523, 353, 12'h050, 12'hfff, 121);
    px1(524, 353, 12'h051, 12'hfff, 121);
    px1(525, 353, 12'h052, 12'h052, 121);
    px1(520, 353, 12'h053, 12'h053, 121);
    px1(521, 353, 12'h054, 12'hfff, 121);
    px1(439, 352, 12'h060, 12'h060, 0);
    px1(440, 352, 12'h061, 12'hfff, 136);
    px1(583, 352, 12'h062, 12'hfff, 136);
    px1(584, 352, 12'h063, 12'h063, 0);
    px1(440, 311, 12'h064, 12'h064, 0);
    px1(440, 456, 12'h065, 12'h065, 0);
    px1(442, 312, 12'h070, 12'haaa, 48);
    // N=9, scale 2 (cell 32): origin (368,240)
    px2(535, 323, 12'h080, 12'hfff, 121);
    px2(534, 323, 12'h081, 12'hfff, 121);
    px2(538, 323, 12'h082, 12'h082, 121);
    px2(367, 320, 12'h083, 12'h083, 0);
    px2(368, 320, 12'h084, 12'hfff, 136);
    px2(655, 320, 12'h085, 12'hfff, 136);
    px2(656, 320, 12'h086, 12'h086, 0);

    // Selection priority in the blink-on phase
    sync(); selx = 4'd0; sely = 4'd0;
    px1(442, 312, 12'h071, 12'h33f, 48);
    sync(); selx = 4'd5; sely = 4'd2;
    px1(523, 353, 12'h072, 12'h33f, 121);
    px1(525, 353, 12'h073, 12'h073, 121);
    sync(); selx = 4'd5; sely = 4'd15;
    px1(523, 353, 12'h074, 12'hfff, 121);
    sync(); selx = 4'd9; sely = 4'd2;
    px1(523, 353, 12'h075, 12'hfff, 121);
    // Empty selected cell: cursor bar on the bottom rows only
    sync(); selx = 4'd1; sely = 4'd1;
    px1(460, 343, 12'h076, 12'h33f, 0);
    px1(460, 342, 12'h077, 12'h077, 0);
    px1(460, 328, 12'h078, 12'h078, 0);
    px2(408, 302, 12'h090, 12'h33f, 0);
    px2(408, 303, 12'h091, 12'h33f, 0);
    px2(408, 301, 12'h092, 12'h092, 0);

    // 32 vsync rising edges switch to the blink-off phase
    for (int k = 0; k < 32; k++) begin
      pxb(0, 0, 12'h0a0, 1'b1);
      pxb(0, 0, 12'h0a0, 1'b0);
    end
    px1(460, 343, 12'h0a1, 12'h0a1, 0);
    px2(408, 302, 12'h0a2, 12'h0a2, 0);
    sync(); selx = 4'd0; sely = 4'd0;
    px1(442, 312, 12'h0a3, 12'haaa, 48);
    // Game off clears the counter: cursor visible again
    sync(); game_on = 1'b0;
    pxb(442, 312, 12'h0a4, 1'b0);
    sync(); game_on = 1'b1;
    px1(442, 312, 12'h0a5, 12'h33f, 48);

    // Mode edges: invalid sizes and game off are pure delays
    sync(); bsize = 3'd1;
    for (int k = 0; k < 20; k++) pxb(430 + 9 * k, 300 + 8 * k, 12'(k * 37 + 5), 1'b0);
    sync(); bsize = 3'd5;
    for (int k = 0; k < 20; k++) pxb(430 + 9 * k, 300 + 8 * k, 12'(k * 41 + 9), 1'b0);
    sync(); bsize = 3'd3; game_on = 1'b0;
    for (int k = 0; k < 20; k++) pxb(430 + 9 * k, 300 + 8 * k, 12'(k * 43 + 3), 1'b0);

    // N = MAX_N: origin (384,256)
    sync(); game_on = 1'b1; bsize = 3'd4; selx = 4'd15; sely = 4'd15;
    px1(467, 297, 12'h0f0, 12'hfff, 121);
    drain();

    // Mid-frame reset clears outputs at once; 3-clock latency after release
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero(1);
    @(negedge clk);
    rst_n = 1'b1;
    pxb(200, 50, 12'hbcd, 1'b0);
    pxb(201, 50, 12'hcde, 1'b0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
